// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and default width.
package serial_addsub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// Single combinational full-adder cell used as the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one full-adder cell; subtract is x + ~y + 1.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             k,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_r;
    state_t             next_state_s;
    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   res_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   s_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    fa_cell u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (fa_cout_s)
    );

    assign res_next_s = {sum_s, res_r[WIDTH-1:1]};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; DONE accepts a new start exactly like IDLE
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(WIDTH - 1)) begin
                    last_s       = 1'b1;
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, counter and registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (accept_s) begin
            a_r     <= x;
            b_r     <= y ^ {WIDTH{k}};
            carry_r <= k;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else if (state_r == SHIFT) begin
            a_r     <= a_r >> 1;
            b_r     <= b_r >> 1;
            res_r   <= res_next_s;
            carry_r <= fa_cout_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            if (last_s) begin
                // carry_r here is the carry into the MSB
                s_r    <= res_next_s;
                cout_r <= fa_cout_s;
                ovf_r  <= carry_r ^ fa_cout_s;
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=4): directed vectors plus random ops vs an arithmetic model.
module tb_serial_addsub;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         k;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int total;
    int bad;

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k     (k),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, s}
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] ya, input logic ka);
        int ux, uy, sx, sy, r, sr;
        logic c, o;
        logic [W-1:0] sm;
        ux = int'(xa);
        uy = int'(ya);
        sx = (ux >= (1 << (W - 1))) ? ux - (1 << W) : ux;
        sy = (uy >= (1 << (W - 1))) ? uy - (1 << W) : uy;
        if (ka) begin
            r  = ux - uy;
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy;
            c  = (r >= (1 << W));
            sr = sx + sy;
        end
        sm = W'(r & ((1 << W) - 1));
        o  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {o, c, sm};
    endfunction

    // One operation: pulse start, optionally disturb inputs during SHIFT, check latency/result/single pulse
    task automatic do_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] ya,
                         input logic ka, input bit disturb);
        logic [W+1:0] e;
        int cycles;
        e = model(xa, ya, ka);
        @(negedge clk);
        x = xa; y = ya; k = ka; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 20) begin
            if (disturb && cycles == 2) begin
                x = ~xa; y = ~ya; k = ~ka; start = 1'b1;
            end else if (disturb && cycles == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        x = xa; y = ya; k = ka;
        chk({tag, "_latency"}, 32'(cycles), 32'(W + 1));
        chk({tag, "_s"}, 32'(s), 32'(e[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        chk({tag, "_hold_s"}, 32'(s), 32'(e[W-1:0]));
    endtask

    initial begin
        logic [W+1:0] e1;
        logic [W+1:0] e2;
        int cycles;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; k = 1'b0; x = '0; y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        rst = 1'b0;

        do_op("add_ex", 4'b1110, 4'b1100, 1'b0, 1'b0);
        chk("add_ex_const", 32'({ovf, cout, s}), 32'({1'b0, 1'b1, 4'b1010}));
        do_op("sub1", 4'b1101, 4'b0010, 1'b1, 1'b0);
        chk("sub1_const", 32'({cout, s}), 32'({1'b1, 4'b1011}));
        do_op("sub2", 4'b1101, 4'b0110, 1'b1, 1'b0);
        chk("sub2_const", 32'({cout, s}), 32'({1'b1, 4'b0111}));
        do_op("sub3", 4'b0010, 4'b1101, 1'b1, 1'b0);
        chk("sub3_const", 32'({cout, s}), 32'({1'b0, 4'b0101}));
        do_op("ovf", 4'b0111, 4'b0001, 1'b0, 1'b0);
        chk("ovf_const", 32'({ovf, cout, s}), 32'({1'b1, 1'b0, 4'b1000}));
        do_op("zero_add", 4'b0000, 4'b0000, 1'b0, 1'b0);
        do_op("eq_sub", 4'b1001, 4'b1001, 1'b1, 1'b0);
        chk("eq_sub_const", 32'({cout, s}), 32'({1'b1, 4'b0000}));
        do_op("ones_add", 4'b1111, 4'b1111, 1'b0, 1'b0);
        chk("ones_add_const", 32'({cout, s}), 32'({1'b1, 4'b1110}));

        // Busy rejection: restart and input changes during SHIFT must not affect the result
        do_op("busy_rej", 4'b0110, 4'b0011, 1'b0, 1'b1);
        chk("busy_rej_idle", 32'(busy), 32'd0);

        // Back-to-back: start held high through DONE
        e1 = model(4'b0101, 4'b0110, 1'b0);
        e2 = model(4'b0011, 4'b1000, 1'b1);
        @(negedge clk);
        x = 4'b0101; y = 4'b0110; k = 1'b0; start = 1'b1;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!done && cycles < 20);
        chk("b2b_first_lat", 32'(cycles), 32'(W + 1));
        chk("b2b_first_s", 32'({ovf, cout, s}), 32'(e1));
        x = 4'b0011; y = 4'b1000; k = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        cycles = 1;
        while (!done && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        chk("b2b_second_gap", 32'(cycles), 32'(W + 1));
        chk("b2b_second_s", 32'({ovf, cout, s}), 32'(e2));

        // Reset in the second SHIFT cycle aborts the operation
        @(negedge clk);
        x = 4'b1011; y = 4'b0100; k = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_outs", 32'({busy, done, cout, ovf, s}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cycles++;
        end
        chk("abort_no_done", 32'(cycles), 32'd0);
        do_op("after_abort", 4'b1011, 4'b0100, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            do_op("rand", W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
